// File: rtl/vga_frame_sched.sv
// vga_frame_sched: VGA raster timing generator plus a two-source frame capture
// scheduler. One source frame (image or Hough accumulator) is handed to the
// VGA handler per vertical blank, round-robin when both sources are ready.
module vga_frame_sched #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       ReqIn0,
   input  logic       ReqIn1,
   output logic       AckIn0,
   output logic       AckIn1,
   output logic       Sel,
   output logic       CapReq,
   input  logic       CapAck,
   output logic       Hsync,
   output logic       Vsync,
   output logic       Active,
   output logic [9:0] PixX,
   output logic [9:0] PixY,
   output logic       FrameStart
);
   // Raster geometry; totals must fit the 10-bit coordinate range.
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0] H_SYNC_S = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] H_SYNC_E = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0] V_SYNC_S = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] V_SYNC_E = 10'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_VB = 2'd1,
      CAPTURE = 2'd2,
      RELEASE = 2'd3
   } state_t;

   logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
   logic       hsync_q, hsync_d, vsync_q, vsync_d;
   logic       active_q, active_d, fs_q, fs_d;
   logic [9:0] pixx_q, pixx_d, pixy_q, pixy_d;

   state_t     state_q;
   logic       sel_q, last_q, capreq_q, ack0_q, ack1_q;
   logic       done_q;        // a capture already completed in this blank
   logic       vblank_s;
   logic       granted_req_s;

   // Next-state of the raster counters: Hcnt wraps per line, Vcnt per frame
   always_comb begin
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (hcnt_q == H_LAST) begin
         hcnt_d = 10'd0;
         if (vcnt_q == V_LAST) begin
            vcnt_d = 10'd0;
         end else begin
            vcnt_d = vcnt_q + 10'd1;
         end
      end else begin
         hcnt_d = hcnt_q + 10'd1;
      end
   end

   // Decode the current counter values; registered below so outputs lag by one
   always_comb begin
      active_d = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
      hsync_d  = !((hcnt_q >= H_SYNC_S) && (hcnt_q < H_SYNC_E));
      vsync_d  = !((vcnt_q >= V_SYNC_S) && (vcnt_q < V_SYNC_E));
      fs_d     = (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
      if (active_d) begin
         pixx_d = hcnt_q;
         pixy_d = vcnt_q;
      end else begin
         pixx_d = 10'd0;
         pixy_d = 10'd0;
      end
   end

   // Raster counters and registered timing outputs
   always_ff @(posedge Clk) begin
      if (Reset) begin
         hcnt_q   <= 10'd0;
         vcnt_q   <= 10'd0;
         hsync_q  <= 1'b1;
         vsync_q  <= 1'b1;
         active_q <= 1'b0;
         fs_q     <= 1'b0;
         pixx_q   <= 10'd0;
         pixy_q   <= 10'd0;
      end else begin
         hcnt_q   <= hcnt_d;
         vcnt_q   <= vcnt_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         active_q <= active_d;
         fs_q     <= fs_d;
         pixx_q   <= pixx_d;
         pixy_q   <= pixy_d;
      end
   end

   assign vblank_s      = (vcnt_q >= V_VIS);
   assign granted_req_s = sel_q ? ReqIn1 : ReqIn0;

   // Capture scheduler: grant, wait for blank, handshake with handler, release
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= IDLE;
         sel_q    <= 1'b0;
         last_q   <= 1'b1;
         capreq_q <= 1'b0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         if (!vblank_s) begin
            done_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (ReqIn0 && ReqIn1) begin
                  sel_q   <= ~last_q;
                  state_q <= WAIT_VB;
               end else if (ReqIn0) begin
                  sel_q   <= 1'b0;
                  state_q <= WAIT_VB;
               end else if (ReqIn1) begin
                  sel_q   <= 1'b1;
                  state_q <= WAIT_VB;
               end else begin
                  state_q <= IDLE;
               end
            end
            WAIT_VB: begin
               if (!granted_req_s) begin
                  state_q <= IDLE;
               end else if (vblank_s && !done_q) begin
                  state_q  <= CAPTURE;
                  capreq_q <= 1'b1;
               end else begin
                  state_q <= WAIT_VB;
               end
            end
            CAPTURE: begin
               // Source dropping its request here is deliberately ignored.
               if (CapAck) begin
                  state_q  <= RELEASE;
                  capreq_q <= 1'b0;
                  done_q   <= 1'b1;
               end else if (!vblank_s) begin
                  state_q  <= WAIT_VB;
                  capreq_q <= 1'b0;
               end else begin
                  state_q <= CAPTURE;
               end
            end
            RELEASE: begin
               ack0_q  <= ~sel_q;
               ack1_q  <= sel_q;
               last_q  <= sel_q;
               state_q <= IDLE;
            end
            default: begin
               state_q  <= IDLE;
               capreq_q <= 1'b0;
            end
         endcase
      end
   end

   assign AckIn0     = ack0_q;
   assign AckIn1     = ack1_q;
   assign Sel        = sel_q;
   assign CapReq     = capreq_q;
   assign Hsync      = hsync_q;
   assign Vsync      = vsync_q;
   assign Active     = active_q;
   assign PixX       = pixx_q;
   assign PixY       = pixy_q;
   assign FrameStart = fs_q;

endmodule

// File: doc/vga_frame_sched.md
VGA_FRAME_SCHED -- requirements
Module: vga_frame_sched

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 The block SHALL have parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal porch and sync lengths in clocks.
REQ-003 The block SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 The block SHALL have parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical porch and sync lengths in lines.
REQ-005 The block SHALL have port Clk, input, 1, the single clock.
REQ-006 The block SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port ReqIn0 / ReqIn1, input, 1 each, source 0/1 (image / Hough accumulator) holds a valid frame.
REQ-008 The block SHALL have port AckIn0 / AckIn1, output, 1 each, one-cycle acknowledge to source 0/1.
REQ-009 The block SHALL have port Sel, output, 1, mux select of the source frame into the VGA handler.
REQ-010 The block SHALL have port CapReq, output, 1, capture request to the VGA handler.
REQ-011 The block SHALL have port CapAck, input, 1, capture acknowledge from the VGA handler.
REQ-012 The block SHALL have port Hsync / Vsync, output, 1 each, active-low sync.
REQ-013 The block SHALL have port Active, output, 1, visible-region flag.
REQ-014 The block SHALL have port PixX / PixY, output, 10 each, visible pixel coordinates.
REQ-015 The block SHALL have port FrameStart, output, 1, one-cycle pulse at pixel (0,0).

Function
REQ-016 Hcnt SHALL count 0..H_TOTAL-1, where H_TOTAL = sum of horizontal parameters (800), and wrap to 0.
REQ-017 Vcnt SHALL increment on Hcnt wrap, count 0..V_TOTAL-1 (525), and wrap to 0.
REQ-018 All timing outputs SHALL be registered, one cycle after the counter values they decode.
REQ-019 Hsync SHALL be 0 iff Hcnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); Vsync SHALL follow the same rule on Vcnt.
REQ-020 Active SHALL be 1 iff Hcnt<H_ACTIVE and Vcnt<V_ACTIVE; PixX/PixY SHALL equal Hcnt/Vcnt when Active, else 0.
REQ-021 FrameStart SHALL pulse for one cycle when Hcnt==0 and Vcnt==0.
REQ-022 VBlank (internal) SHALL be defined as Vcnt>=V_ACTIVE.
REQ-023 The FSM SHALL have states IDLE, WAIT_VB, CAPTURE, RELEASE.
REQ-024 In IDLE, if exactly one ReqIn is high, the FSM SHALL grant it; if both are high, it SHALL grant the source not in Last (round robin); it SHALL then latch Sel and go to WAIT_VB.
REQ-025 In WAIT_VB, if the granted ReqIn drops, the FSM SHALL return to IDLE with no ack.
REQ-026 In WAIT_VB, when VBlank is true, the FSM SHALL go to CAPTURE and assert CapReq from the next cycle.
REQ-027 In CAPTURE, CapReq SHALL stay high until CapAck; on CapAck it SHALL go to RELEASE and drop CapReq the following cycle.
REQ-028 In CAPTURE, if VBlank ends before CapAck, CapReq SHALL drop and the FSM SHALL return to WAIT_VB to retry in the next blank.
REQ-029 In CAPTURE, if the granted ReqIn drops, the FSM SHALL ignore it.
REQ-030 In RELEASE, AckIn[Sel] SHALL be high for exactly one cycle, Last SHALL be updated to Sel, and the FSM SHALL go to IDLE.
REQ-031 Sel SHALL be stable from grant until the FSM returns to IDLE.
REQ-032 AckIn0 and AckIn1 SHALL never be high in the same cycle.
REQ-033 At most one capture SHALL occur per vertical blank.
REQ-034 If CapAck arrives while the FSM is not in CAPTURE, it SHALL be ignored.

Reset
REQ-035 On Reset high at a Clk edge, Hcnt, Vcnt, PixX and PixY SHALL be 0.
REQ-036 On Reset, Hsync and Vsync SHALL be 1, Active 1 on the first post-reset cycle (registered decode of (0,0)), FrameStart 1 on that cycle, and all other outputs 0.
REQ-037 On Reset, the FSM SHALL go to IDLE, Sel 0, Last 1 (source 0 wins first tie), and CapReq 0 and any pending ack SHALL be discarded.
REQ-038 Reset mid-CAPTURE SHALL drop CapReq on the next cycle and issue no AckIn.

Verification
REQ-039 Free-run 2 frames -> FrameStart period 420000 clocks; Hsync low 96 clocks/line starting at Hcnt 656; Vsync low lines 490-491.
REQ-040 ReqIn0=ReqIn1=1 held from reset, CapAck returned 2 cycles after CapReq -> grants alternate 0,1,0,1 on successive vblanks; one AckIn per frame.
REQ-041 ReqIn1 raised at line 100, CapAck 3 cycles after CapReq -> CapReq rises at line 480 Hcnt 1; AckIn1 pulses 1 cycle after the cycle in which CapReq drops.
REQ-042 CapAck withheld through the whole blank -> CapReq drops at line 0, reasserts in the next blank; no AckIn until CapAck is seen.
REQ-043 ReqIn0 dropped in WAIT_VB -> no CapReq, back to IDLE; ReqIn0 dropped in CAPTURE -> capture completes and AckIn0 is still issued.
REQ-044 Reset pulsed during CAPTURE -> CapReq 0 next cycle, counters 0, no AckIn, Sel 0.
